exec_seq_ctrl: RTL
==================

Name: exec_seq_ctrl

Overview:
Issue-side sequencer for the execute stage's multi-cycle functional units: integer multiplier, integer divider, FPU add/sub, FPU mul, FPU inv and FPU sqrt.
- Decodes the issued instruction and classifies it as single-cycle or multi-cycle.
- For multi-cycle ops, holds the pipeline with a stall for exactly the unit's latency, then pulses result_valid when the execute result mux output is usable.
- Sits beside the execute stage. Its stall is ORed with the UART busy signal by the pipeline control.

Parameters:
MUL_LAT, 3, total cycles until MUL32_32 output valid (accept cycle included)
DIV_LAT, 36, same for DIV32
FADD_LAT, 2, fadd/fsub
FMUL_LAT, 2, fmul
FINV_LAT, 4, finv
FSQRT_LAT, 4, fsqrt
CNT_W, 6, latency counter width; must satisfy 2**CNT_W > max latency

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse per issued instruction
hazard  in  1  issue blocked this cycle; start ignored while high
op_type  in  2  2'b00 I-type, 2'b01 R-type, 2'b10 FPU
instr  in  6  opcode/funct, compared against package constants
stall  out  1  hold upstream pipeline
result_valid  out  1  one-cycle pulse: multi-cycle result is valid on d
unit  out  6  one-hot active unit {SQRT,INV,FMUL,FADD,DIV,MUL}; 0 when idle
proto_err  out  1  sticky; set when start arrives while BUSY
stall_cnt  out  32  saturating count of cycles with stall=1

Behaviour:
- Reset (rstn=0 at a clk edge) forces:
  - state=IDLE, cnt=0
  - result_valid=0, unit=0, proto_err=0, stall_cnt=0
  - This applies mid-operation too. stall is low in the cycle after reset.
- Decode (combinational):
  - op_type 01 with FUNC_MULT selects MUL; FUNC_DIV selects DIV.
  - op_type 10 with FPU_ADD or FPU_SUB selects FADD; FPU_MUL selects FMUL; FPU_INV selects INV; FPU_SQRT selects SQRT.
  - Everything else is single-cycle. So is any class whose latency parameter is 1.
- accept = start & ~hazard & (state==IDLE) & multi-cycle class.
- stall = accept | (state==BUSY). Combinational, so stall is high in the accept cycle itself.
- FSM, 2 states:
  - IDLE, on accept: cnt <= LAT-1, unit <= decoded one-hot, state <= BUSY.
  - BUSY, cnt>1: cnt <= cnt-1.
  - BUSY, cnt==1: state <= IDLE, unit <= 0, result_valid <= 1 (registered).
- Timing: stall is high for exactly LAT cycles. result_valid is high in the first cycle after the stall window (stall=0 there), for 1 cycle.
- start & hazard: no accept and no stall from this block. The instruction is re-presented later with a fresh start.
- Single-cycle op: stall=0 and result_valid stays 0. The pipeline consumes d directly.
- start during BUSY: ignored (no reload), proto_err <= 1 and held until reset.
- Back-to-back: a new start is legal in the result_valid cycle (state is IDLE). The resulting accept may coincide with result_valid=1.
- stall_cnt increments on every stall=1 cycle and saturates at 32'hFFFFFFFF.
- Operand forwarding and register capture are not handled here. The execute stage registers its operands itself; this block only controls time.

Decomposition:
- Shared package (constant): OP_/FUNC_/FPU_ codes (already present).
- New in the package:
  - unit one-hot localparams UNIT_MUL..UNIT_SQRT
  - typedef enum logic {SEQ_IDLE, SEQ_BUSY} seq_state_t
- One sub-module, exec_seq_decode: combinational mapping (op_type, instr) to one-hot unit and latency. Keeps the FSM free of opcode logic.

Test Plan:
- FUNC_MULT start, hazard=0 -> stall=1 for cycles 0..2, result_valid=1 at cycle 3 only, unit=6'b000001 cycles 0(+1)..2, stall_cnt=3.
- FUNC_DIV start -> stall high for exactly 36 cycles, result_valid at cycle 36. Then FPU_SQRT start at cycle 36 -> accepted, stall cycles 36..39, result_valid at 40.
- OP_ADDI start and FUNC_ADD start -> stall never high, result_valid never high, stall_cnt unchanged.
- FPU_MUL start with hazard=1 -> no stall. Re-issue with hazard=0 next cycle -> stall 2 cycles, result_valid after.
- FPU_INV accepted, extra start at BUSY cycle 2 -> proto_err=1, result_valid still at cycle 4, no reload.
- FUNC_DIV accepted, rstn=0 at cycle 10 -> cycle 11: stall=0, unit=0, stall_cnt=0, proto_err=0, and no result_valid afterward.

Source files
------------

// File: rtl/exec_seq_ctrl_pkg.sv
// Shared constants for the execute-stage sequencer.
// Holds the op-class codes, the opcode/funct codes, the one-hot unit
// encodings and the sequencer state type.
package exec_seq_ctrl_pkg;

    // op_type classes
    localparam logic [1:0] OP_ITYPE = 2'b00;
    localparam logic [1:0] OP_RTYPE = 2'b01;
    localparam logic [1:0] OP_FPU   = 2'b10;

    // I-type opcodes
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // R-type funct codes
    localparam logic [5:0] FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_MULT = 6'h18;
    localparam logic [5:0] FUNC_DIV  = 6'h1A;

    // FPU funct codes
    localparam logic [5:0] FPU_ADD  = 6'h00;
    localparam logic [5:0] FPU_SUB  = 6'h01;
    localparam logic [5:0] FPU_MUL  = 6'h02;
    localparam logic [5:0] FPU_INV  = 6'h03;
    localparam logic [5:0] FPU_SQRT = 6'h04;

    // One-hot unit select {SQRT,INV,FMUL,FADD,DIV,MUL}
    localparam logic [5:0] UNIT_NONE = 6'b000000;
    localparam logic [5:0] UNIT_MUL  = 6'b000001;
    localparam logic [5:0] UNIT_DIV  = 6'b000010;
    localparam logic [5:0] UNIT_FADD = 6'b000100;
    localparam logic [5:0] UNIT_FMUL = 6'b001000;
    localparam logic [5:0] UNIT_INV  = 6'b010000;
    localparam logic [5:0] UNIT_SQRT = 6'b100000;

    typedef enum logic {SEQ_IDLE, SEQ_BUSY} seq_state_t;

endpackage

// File: rtl/exec_seq_ctrl_decode.sv
// Combinational decode of an issued instruction into its multi-cycle unit.
// Ports:
//   op_type, instr : instruction class and opcode/funct
//   unit_o         : one-hot unit, zero for single-cycle instructions
//   lat_o          : total latency of that unit (accept cycle included)
//   multi_o        : instruction needs the sequencer
module exec_seq_ctrl_decode
    import exec_seq_ctrl_pkg::*;
#(
    parameter int MUL_LAT   = 3,
    parameter int DIV_LAT   = 36,
    parameter int FADD_LAT  = 2,
    parameter int FMUL_LAT  = 2,
    parameter int FINV_LAT  = 4,
    parameter int FSQRT_LAT = 4,
    parameter int CNT_W     = 6
) (
    input  logic [1:0]       op_type,
    input  logic [5:0]       instr,
    output logic [5:0]       unit_o,
    output logic [CNT_W-1:0] lat_o,
    output logic             multi_o
);

    logic [5:0]       unit_raw;
    logic [CNT_W-1:0] lat_raw;

    always_comb begin
        unit_raw = UNIT_NONE;
        lat_raw  = '0;
        if (op_type == OP_RTYPE) begin
            case (instr)
                FUNC_MULT: begin unit_raw = UNIT_MUL; lat_raw = CNT_W'(MUL_LAT); end
                FUNC_DIV:  begin unit_raw = UNIT_DIV; lat_raw = CNT_W'(DIV_LAT); end
                default:   ;
            endcase
        end else if (op_type == OP_FPU) begin
            case (instr)
                FPU_ADD, FPU_SUB: begin unit_raw = UNIT_FADD; lat_raw = CNT_W'(FADD_LAT);  end
                FPU_MUL:          begin unit_raw = UNIT_FMUL; lat_raw = CNT_W'(FMUL_LAT);  end
                FPU_INV:          begin unit_raw = UNIT_INV;  lat_raw = CNT_W'(FINV_LAT);  end
                FPU_SQRT:         begin unit_raw = UNIT_SQRT; lat_raw = CNT_W'(FSQRT_LAT); end
                default:          ;
            endcase
        end
    end

    // A unit configured with latency 1 finishes in the issue cycle, so it is
    // treated exactly like any other single-cycle instruction.
    assign multi_o = (unit_raw != UNIT_NONE) && (lat_raw > CNT_W'(1));
    assign unit_o  = multi_o ? unit_raw : UNIT_NONE;
    assign lat_o   = lat_raw;

endmodule

// File: rtl/exec_seq_ctrl.sv
// Issue-side sequencer for the execute stage's multi-cycle units.
// Stalls the pipeline for the unit latency, then pulses result_valid.
// Ports:
//   clk, rstn      : clock, synchronous active-low reset
//   start, hazard  : issue pulse and issue-blocked qualifier
//   op_type, instr : instruction being issued
//   stall          : hold upstream pipeline (combinational)
//   result_valid   : one-cycle pulse after the stall window
//   unit           : one-hot active unit, zero when idle
//   proto_err      : sticky, start seen while busy
//   stall_cnt      : saturating count of stalled cycles
module exec_seq_ctrl
    import exec_seq_ctrl_pkg::*;
#(
    parameter int MUL_LAT   = 3,
    parameter int DIV_LAT   = 36,
    parameter int FADD_LAT  = 2,
    parameter int FMUL_LAT  = 2,
    parameter int FINV_LAT  = 4,
    parameter int FSQRT_LAT = 4,
    parameter int CNT_W     = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        hazard,
    input  logic [1:0]  op_type,
    input  logic [5:0]  instr,
    output logic        stall,
    output logic        result_valid,
    output logic [5:0]  unit,
    output logic        proto_err,
    output logic [31:0] stall_cnt
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       unit_q, unit_d;
    logic             rv_q, rv_d;
    logic             perr_q, perr_d;
    logic [31:0]      scnt_q, scnt_d;

    logic [5:0]       dec_unit;
    logic [CNT_W-1:0] dec_lat;
    logic             dec_multi;
    logic             accept;

    exec_seq_ctrl_decode #(
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .FADD_LAT(FADD_LAT),
        .FMUL_LAT(FMUL_LAT), .FINV_LAT(FINV_LAT), .FSQRT_LAT(FSQRT_LAT),
        .CNT_W(CNT_W)
    ) u_dec (
        .op_type(op_type),
        .instr  (instr),
        .unit_o (dec_unit),
        .lat_o  (dec_lat),
        .multi_o(dec_multi)
    );

    assign accept = start && !hazard && (state_q == SEQ_IDLE) && dec_multi;
    assign stall  = accept || (state_q == SEQ_BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unit_d  = unit_q;
        rv_d    = 1'b0;
        perr_d  = perr_q;
        scnt_d  = scnt_q;
        case (state_q)
            SEQ_IDLE: begin
                if (accept) begin
                    // The accept cycle is the first stalled cycle.
                    cnt_d   = dec_lat - CNT_W'(1);
                    unit_d  = dec_unit;
                    state_d = SEQ_BUSY;
                end
            end
            SEQ_BUSY: begin
                if (start && !hazard) perr_d = 1'b1;
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = SEQ_IDLE;
                    unit_d  = UNIT_NONE;
                    rv_d    = 1'b1;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
        if (stall && (scnt_q != 32'hFFFF_FFFF)) scnt_d = scnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
            unit_q  <= UNIT_NONE;
            rv_q    <= 1'b0;
            perr_q  <= 1'b0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            unit_q  <= unit_d;
            rv_q    <= rv_d;
            perr_q  <= perr_d;
            scnt_q  <= scnt_d;
        end
    end

    assign result_valid = rv_q;
    assign unit         = unit_q;
    assign proto_err    = perr_q;
    assign stall_cnt    = scnt_q;

endmodule
